// File: rtl/tboom_freelist_alloc_ctrl.sv
// rtl/tboom_freelist_alloc_ctrl.sv - rename freelist sequencer: seeding, dual-lane alloc, frees, branch checkpoint
module tboom_freelist_alloc_ctrl #(
  parameter  int PREG_W    = 6,
  parameter  int NUM_PREGS = 16,
  parameter  int NUM_AREGS = 8,
  localparam int FL_DEPTH  = NUM_PREGS - NUM_AREGS,
  localparam int CNT_W     = $clog2(FL_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              req0,
  input  logic              req1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              alloc_vld0,
  output logic              alloc_vld1,
  output logic [PREG_W-1:0] alloc_tag0,
  output logic [PREG_W-1:0] alloc_tag1,
  input  logic              free0_vld,
  input  logic              free1_vld,
  input  logic [PREG_W-1:0] free0_tag,
  input  logic [PREG_W-1:0] free1_tag,
  input  logic              br_ckpt,
  input  logic              br_resolve,
  input  logic              br_mispredict,
  output logic              ckpt_busy,
  output logic [CNT_W-1:0]  free_count,
  output logic              err,
  output logic              fl_i0_read_enable,
  output logic              fl_i1_read_enable,
  output logic              fl_i0_write_enable,
  output logic              fl_i1_write_enable,
  output logic [PREG_W-1:0] fl_i0_data_in,
  output logic [PREG_W-1:0] fl_i1_data_in,
  output logic              fl_checkpoint,
  output logic              fl_restore,
  input  logic [PREG_W-1:0] fl_i0_data_out,
  input  logic [PREG_W-1:0] fl_i1_data_out,
  input  logic              fl_full,
  input  logic              fl_one_remaining,
  input  logic              fl_empty
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [PREG_W:0] SEED_FIRST = (PREG_W+1)'(NUM_AREGS);
  localparam logic [PREG_W:0] SEED_LAST  = (PREG_W+1)'(NUM_PREGS - 2);

  state_t            state_q, state_d;
  logic [PREG_W:0]   seed_ptr_q, seed_ptr_d;
  logic [CNT_W-1:0]  free_count_q, free_count_d;
  logic [CNT_W-1:0]  ckpt_count_q, ckpt_count_d;
  logic [CNT_W-1:0]  frees_since_q, frees_since_d;
  logic              ckpt_busy_q, ckpt_busy_d;
  logic              err_q, err_d;
  logic              alloc_vld0_q, alloc_vld0_d;
  logic              alloc_vld1_q, alloc_vld1_d;
  logic              lane1_i1_q, lane1_i1_d;

  logic              run, seeding, alloc_ok, one_slot;
  logic              acc0, acc1, free_drop;
  logic              restore_go, take_ckpt, ckpt_refused, misp_no_ckpt;
  logic [CNT_W-1:0]  n_acc, n_gnt;

  // Branch/free qualification shared by the output and next-state logic
  always_comb begin
    run          = (state_q == S_RUN);
    seeding      = (state_q == S_INIT) & ~rst;
    alloc_ok     = run & ~fl_empty & ~br_ckpt & ~br_mispredict;
    one_slot     = (free_count_q == CNT_W'(FL_DEPTH - 1));
    acc0         = run & free0_vld & ~fl_full;
    acc1         = run & free1_vld & ~fl_full & ~(free0_vld & one_slot);
    free_drop    = run & ((free0_vld & ~acc0) | (free1_vld & ~acc1));
    restore_go   = run & br_mispredict & ckpt_busy_q;
    misp_no_ckpt = run & br_mispredict & ~ckpt_busy_q;
    take_ckpt    = run & ~br_mispredict & br_ckpt & (~ckpt_busy_q | br_resolve);
    ckpt_refused = run & ~br_mispredict & br_ckpt & ckpt_busy_q & ~br_resolve;
    n_acc        = CNT_W'(acc0) + CNT_W'(acc1);
    n_gnt        = CNT_W'(gnt0) + CNT_W'(gnt1);
  end

  // State register: INIT seeds the freelist, RUN serves rename and commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave INIT once the last pair of tags has been written
  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && seed_ptr_q == SEED_LAST) begin
      state_d = S_RUN;
    end
  end

  // FSM outputs: grants, freelist port enables/data and branch strobes
  always_comb begin
    ready              = run;
    gnt0               = alloc_ok & req0;
    gnt1               = alloc_ok & req1 & (gnt0 | ~req0) & ~(fl_one_remaining & gnt0);
    fl_i0_read_enable  = gnt0 | gnt1;
    fl_i1_read_enable  = gnt0 & gnt1;
    fl_i0_write_enable = seeding | acc0;
    fl_i1_write_enable = seeding | acc1;
    fl_i0_data_in      = seeding ? seed_ptr_q[PREG_W-1:0] : free0_tag;
    fl_i1_data_in      = seeding ? (seed_ptr_q[PREG_W-1:0] + PREG_W'(1)) : free1_tag;
    fl_checkpoint      = take_ckpt;
    fl_restore         = restore_go;
  end

  // Datapath next values: counts, checkpoint bookkeeping, alloc tracking
  always_comb begin
    seed_ptr_d    = seed_ptr_q;
    free_count_d  = free_count_q;
    ckpt_count_d  = ckpt_count_q;
    frees_since_d = frees_since_q;
    ckpt_busy_d   = ckpt_busy_q;
    err_d         = err_q | free_drop | ckpt_refused | misp_no_ckpt;
    alloc_vld0_d  = gnt0;
    alloc_vld1_d  = gnt1;
    lane1_i1_d    = gnt0 & gnt1;
    if (state_q == S_INIT) begin
      seed_ptr_d   = seed_ptr_q + (PREG_W+1)'(2);
      free_count_d = free_count_q + CNT_W'(2);
    end else if (restore_go) begin
      // Squashed allocations return; frees since the snapshot survive
      free_count_d = ckpt_count_q + frees_since_q + n_acc;
      ckpt_busy_d  = 1'b0;
    end else begin
      free_count_d = free_count_q - n_gnt + n_acc;
      if (take_ckpt) begin
        ckpt_count_d  = free_count_q;
        frees_since_d = n_acc;
        ckpt_busy_d   = 1'b1;
      end else if (br_resolve) begin
        ckpt_busy_d = 1'b0;
      end else if (ckpt_busy_q) begin
        frees_since_d = frees_since_q + n_acc;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_ptr_q    <= SEED_FIRST;
      free_count_q  <= '0;
      ckpt_count_q  <= '0;
      frees_since_q <= '0;
      ckpt_busy_q   <= 1'b0;
      err_q         <= 1'b0;
      alloc_vld0_q  <= 1'b0;
      alloc_vld1_q  <= 1'b0;
      lane1_i1_q    <= 1'b0;
    end else begin
      seed_ptr_q    <= seed_ptr_d;
      free_count_q  <= free_count_d;
      ckpt_count_q  <= ckpt_count_d;
      frees_since_q <= frees_since_d;
      ckpt_busy_q   <= ckpt_busy_d;
      err_q         <= err_d;
      alloc_vld0_q  <= alloc_vld0_d;
      alloc_vld1_q  <= alloc_vld1_d;
      lane1_i1_q    <= lane1_i1_d;
    end
  end

  // Allocation results: tags come from the freelist read register; a restore squashes them
  always_comb begin
    alloc_vld0 = alloc_vld0_q & ~restore_go;
    alloc_vld1 = alloc_vld1_q & ~restore_go;
    alloc_tag0 = alloc_vld0 ? fl_i0_data_out : '0;
    alloc_tag1 = alloc_vld1 ? (lane1_i1_q ? fl_i1_data_out : fl_i0_data_out) : '0;
    ckpt_busy  = ckpt_busy_q;
    free_count = free_count_q;
    err        = err_q;
  end

endmodule

// File: tb/tb_tboom_freelist_alloc_ctrl.sv
// tb/tb_tboom_freelist_alloc_ctrl.sv - self-checking bench for tboom_freelist_alloc_ctrl
module tb_tboom_freelist_alloc_ctrl;
  localparam int PREG_W    = 6;
  localparam int NUM_PREGS = 16;
  localparam int NUM_AREGS = 8;
  localparam int FL_DEPTH  = NUM_PREGS - NUM_AREGS;
  localparam int CNT_W     = $clog2(FL_DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ready, req0, req1, gnt0, gnt1, alloc_vld0, alloc_vld1;
  logic [PREG_W-1:0] alloc_tag0, alloc_tag1, free0_tag, free1_tag;
  logic free0_vld, free1_vld, br_ckpt, br_resolve, br_mispredict, ckpt_busy, err;
  logic [CNT_W-1:0] free_count;
  logic fl_i0_read_enable, fl_i1_read_enable, fl_i0_write_enable, fl_i1_write_enable;
  logic [PREG_W-1:0] fl_i0_data_in, fl_i1_data_in, fl_i0_data_out, fl_i1_data_out;
  logic fl_checkpoint, fl_restore, fl_full, fl_one_remaining, fl_empty;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tboom_freelist_alloc_ctrl #(.PREG_W(PREG_W), .NUM_PREGS(NUM_PREGS), .NUM_AREGS(NUM_AREGS)) dut (
    .clk(clk), .rst(rst), .ready(ready), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .alloc_vld0(alloc_vld0), .alloc_vld1(alloc_vld1), .alloc_tag0(alloc_tag0), .alloc_tag1(alloc_tag1),
    .free0_vld(free0_vld), .free1_vld(free1_vld), .free0_tag(free0_tag), .free1_tag(free1_tag),
    .br_ckpt(br_ckpt), .br_resolve(br_resolve), .br_mispredict(br_mispredict),
    .ckpt_busy(ckpt_busy), .free_count(free_count), .err(err),
    .fl_i0_read_enable(fl_i0_read_enable), .fl_i1_read_enable(fl_i1_read_enable),
    .fl_i0_write_enable(fl_i0_write_enable), .fl_i1_write_enable(fl_i1_write_enable),
    .fl_i0_data_in(fl_i0_data_in), .fl_i1_data_in(fl_i1_data_in),
    .fl_checkpoint(fl_checkpoint), .fl_restore(fl_restore),
    .fl_i0_data_out(fl_i0_data_out), .fl_i1_data_out(fl_i1_data_out),
    .fl_full(fl_full), .fl_one_remaining(fl_one_remaining), .fl_empty(fl_empty)
  );

  // Freelist instance model: circular buffer, checkpoint saves the read pointer
  logic [PREG_W-1:0] fl_mem [FL_DEPTH];
  int fl_rd, fl_wr, fl_saved_rd, fl_bad;
  assign fl_full          = (fl_wr - fl_rd) == FL_DEPTH;
  assign fl_one_remaining = (fl_wr - fl_rd) == 1;
  assign fl_empty         = (fl_wr - fl_rd) == 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fl_rd <= 0; fl_wr <= 0; fl_saved_rd <= 0;
      fl_i0_data_out <= '0; fl_i1_data_out <= '0;
    end else begin
      if (fl_i0_read_enable && (fl_wr - fl_rd) < 1) fl_bad <= fl_bad + 1;
      if (fl_i1_read_enable && (fl_wr - fl_rd) < 2) fl_bad <= fl_bad + 1;
      if ((fl_wr - fl_rd) + int'(fl_i0_write_enable) + int'(fl_i1_write_enable) > FL_DEPTH) fl_bad <= fl_bad + 1;
      if (fl_i0_write_enable) fl_mem[fl_wr % FL_DEPTH] <= fl_i0_data_in;
      if (fl_i1_write_enable) fl_mem[(fl_wr + int'(fl_i0_write_enable)) % FL_DEPTH] <= fl_i1_data_in;
      fl_wr <= fl_wr + int'(fl_i0_write_enable) + int'(fl_i1_write_enable);
      if (fl_i0_read_enable) fl_i0_data_out <= fl_mem[fl_rd % FL_DEPTH];
      if (fl_i1_read_enable) fl_i1_data_out <= fl_mem[(fl_rd + 1) % FL_DEPTH];
      if (fl_checkpoint) fl_saved_rd <= fl_rd;
      fl_rd <= fl_restore ? fl_saved_rd : fl_rd + int'(fl_i0_read_enable) + int'(fl_i1_read_enable);
    end
  end

  // Reference model: the free tags as an ordered queue plus a branch snapshot
  logic [PREG_W-1:0] rq[$], snap_q[$], since_q[$];
  bit r_ready, r_busy, r_err;
  int r_seed;
  bit pend_v0, pend_v1;
  logic [PREG_W-1:0] pend_t0, pend_t1;

  // Expected and observed values for the cycle most recently driven
  bit e_gnt0, e_gnt1, e_re0, e_re1, e_we0, e_we1, e_ckpt, e_restore, e_av0, e_av1;
  bit e_acc0, e_acc1, e_drop, e_ready, e_busy, e_err;
  logic [PREG_W-1:0] e_at0, e_at1, e_wd0, e_wd1;
  int e_cnt;
  logic o_gnt0, o_gnt1, o_re0, o_re1, o_we0, o_we1, o_ckpt, o_restore, o_av0, o_av1;
  logic o_ready, o_busy, o_err;
  logic [PREG_W-1:0] o_at0, o_at1, o_wd0, o_wd1;
  logic [CNT_W-1:0] o_cnt;

  task automatic model_reset();
    rq.delete(); snap_q.delete(); since_q.delete();
    r_ready = 0; r_busy = 0; r_err = 0; r_seed = NUM_AREGS;
    pend_v0 = 0; pend_v1 = 0; pend_t0 = '0; pend_t1 = '0;
  endtask

  task automatic drive_cycle(input bit r0, input bit r1,
                             input bit f0v, input logic [PREG_W-1:0] f0t,
                             input bit f1v, input logic [PREG_W-1:0] f1t,
                             input bit ck, input bit res, input bit mis);
    logic [PREG_W-1:0] nf[$];
    bit ok;
    @(negedge clk);
    req0 = r0; req1 = r1; free0_vld = f0v; free0_tag = f0t; free1_vld = f1v; free1_tag = f1t;
    br_ckpt = ck; br_resolve = res; br_mispredict = mis;
    #1;
    ok        = r_ready && rq.size() > 0 && !ck && !mis;
    e_gnt0    = ok && r0;
    e_gnt1    = ok && r1 && (e_gnt0 || !r0) && !(rq.size() == 1 && e_gnt0);
    e_re0     = e_gnt0 || e_gnt1;
    e_re1     = e_gnt0 && e_gnt1;
    e_acc0    = r_ready && f0v && rq.size() < FL_DEPTH;
    e_acc1    = r_ready && f1v && rq.size() < FL_DEPTH && !(f0v && rq.size() == FL_DEPTH - 1);
    e_drop    = r_ready && ((f0v && !e_acc0) || (f1v && !e_acc1));
    e_restore = r_ready && mis && r_busy;
    e_ckpt    = r_ready && !mis && ck && (!r_busy || res);
    e_av0     = pend_v0 && !e_restore;
    e_av1     = pend_v1 && !e_restore;
    e_at0     = e_av0 ? pend_t0 : '0;
    e_at1     = e_av1 ? pend_t1 : '0;
    e_we0     = !r_ready || e_acc0;
    e_we1     = !r_ready || e_acc1;
    e_wd0     = !r_ready ? PREG_W'(r_seed) : f0t;
    e_wd1     = !r_ready ? PREG_W'(r_seed + 1) : f1t;
    e_ready   = r_ready; e_busy = r_busy; e_err = r_err; e_cnt = rq.size();
    o_gnt0 = gnt0; o_gnt1 = gnt1; o_re0 = fl_i0_read_enable; o_re1 = fl_i1_read_enable;
    o_we0 = fl_i0_write_enable; o_we1 = fl_i1_write_enable; o_wd0 = fl_i0_data_in; o_wd1 = fl_i1_data_in;
    o_ckpt = fl_checkpoint; o_restore = fl_restore; o_av0 = alloc_vld0; o_av1 = alloc_vld1;
    o_at0 = alloc_tag0; o_at1 = alloc_tag1; o_ready = ready; o_busy = ckpt_busy; o_err = err;
    o_cnt = free_count;
    @(posedge clk);
    if (!r_ready) begin
      rq.push_back(PREG_W'(r_seed)); rq.push_back(PREG_W'(r_seed + 1));
      r_seed += 2;
      if (r_seed == NUM_PREGS) r_ready = 1;
      pend_v0 = 0; pend_v1 = 0;
    end else begin
      pend_v0 = e_gnt0; pend_v1 = e_gnt1;
      if (e_gnt0) pend_t0 = rq.pop_front();
      if (e_gnt1) pend_t1 = rq.pop_front();
      if (e_acc0) nf.push_back(f0t);
      if (e_acc1) nf.push_back(f1t);
      if (e_drop) r_err = 1;
      if (mis && r_busy) begin
        rq.delete();
        foreach (snap_q[i]) rq.push_back(snap_q[i]);
        foreach (since_q[i]) rq.push_back(since_q[i]);
        foreach (nf[i]) rq.push_back(nf[i]);
        r_busy = 0;
      end else begin
        if (mis) r_err = 1;
        else if (ck && r_busy && !res) r_err = 1;
        if (e_ckpt) begin
          snap_q = rq; since_q = nf; r_busy = 1;
        end else if (!mis && res) begin
          r_busy = 0;
        end else if (r_busy) begin
          foreach (nf[i]) since_q.push_back(nf[i]);
        end
        foreach (nf[i]) rq.push_back(nf[i]);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, '0, 0, '0, 0, 0, 0);
  endtask

  task automatic assert_reset();
    rst = 1;
    req0 = 0; req1 = 0; free0_vld = 0; free1_vld = 0; free0_tag = '0; free1_tag = '0;
    br_ckpt = 0; br_resolve = 0; br_mispredict = 0;
    model_reset();
  endtask

  task automatic release_reset();
    @(posedge clk); #2; rst = 0;
  endtask

  task automatic reseed();
    @(negedge clk); #2; assert_reset(); release_reset(); idle(FL_DEPTH / 2);
  endtask

  task automatic test_reset();
    assert_reset();
    #3;
    n_tests++;
    if ({ready, gnt0, gnt1, alloc_vld0, alloc_vld1, ckpt_busy, err, fl_i0_write_enable, fl_i1_write_enable,
         fl_i0_read_enable, fl_checkpoint, fl_restore} !== 12'b0) begin
      n_fail++; $display("FAIL reset_ctl got %b want 0", {ready, gnt0, gnt1, alloc_vld0, alloc_vld1, ckpt_busy, err,
        fl_i0_write_enable, fl_i1_write_enable, fl_i0_read_enable, fl_checkpoint, fl_restore});
    end
    n_tests++;
    if (free_count !== '0 || alloc_tag0 !== '0 || alloc_tag1 !== '0) begin
      n_fail++; $display("FAIL reset_count got %0d/%0d/%0d want 0", free_count, alloc_tag0, alloc_tag1);
    end
    release_reset();
  endtask

  task automatic test_seeding();
    for (int k = 0; k < FL_DEPTH / 2; k++) begin
      drive_cycle(1, 1, 1, 6'd3, 0, '0, 0, 0, 0);
      n_tests++;
      if (o_we0 !== 1 || o_we1 !== 1 || o_wd0 !== PREG_W'(8 + 2 * k) || o_wd1 !== PREG_W'(9 + 2 * k) ||
          o_gnt0 !== 0 || o_ready !== 0) begin
        n_fail++; $display("FAIL seed_write%0d got we=%b%b d=%0d,%0d gnt=%b ready=%b want 11 %0d,%0d 0 0",
          k, o_we0, o_we1, o_wd0, o_wd1, o_gnt0, o_ready, 8 + 2 * k, 9 + 2 * k);
      end
    end
    idle(1);
    n_tests++;
    if (o_ready !== 1 || o_cnt !== 8 || o_we0 !== 0) begin
      n_fail++; $display("FAIL seed_done got ready=%b cnt=%0d we=%b want 1 8 0", o_ready, o_cnt, o_we0);
    end
  endtask

  task automatic test_dual_alloc();
    drive_cycle(1, 1, 0, '0, 0, '0, 0, 0, 0);
    n_tests++;
    if ({o_gnt0, o_gnt1, o_re0, o_re1} !== 4'b1111) begin
      n_fail++; $display("FAIL dual_gnt got %b want 1111", {o_gnt0, o_gnt1, o_re0, o_re1});
    end
    drive_cycle(0, 1, 0, '0, 0, '0, 0, 0, 0);
    n_tests++;
    if (o_av0 !== 1 || o_av1 !== 1 || o_at0 !== 8 || o_at1 !== 9 || o_cnt !== 6) begin
      n_fail++; $display("FAIL dual_tags got %b%b %0d %0d cnt=%0d want 11 8 9 6", o_av0, o_av1, o_at0, o_at1, o_cnt);
    end
    n_tests++;
    if ({o_gnt0, o_gnt1, o_re0, o_re1} !== 4'b0110) begin
      n_fail++; $display("FAIL lane1_only_gnt got %b want 0110", {o_gnt0, o_gnt1, o_re0, o_re1});
    end
    drive_cycle(0, 0, 1, 6'd2, 0, '0, 0, 0, 0);
    n_tests++;
    if (o_av0 !== 0 || o_av1 !== 1 || o_at1 !== 10 || o_cnt !== 5) begin
      n_fail++; $display("FAIL lane1_only_tag got %b%b %0d cnt=%0d want 01 10 5", o_av0, o_av1, o_at1, o_cnt);
    end
  endtask

  task automatic test_ckpt_restore();
    drive_cycle(1, 1, 0, '0, 0, '0, 1, 0, 0);
    n_tests++;
    if (o_cnt !== 6 || o_ckpt !== 1 || o_gnt0 !== 0 || o_gnt1 !== 0) begin
      n_fail++; $display("FAIL ckpt_take got cnt=%0d ckpt=%b gnt=%b%b want 6 1 00", o_cnt, o_ckpt, o_gnt0, o_gnt1);
    end
    drive_cycle(1, 1, 0, '0, 0, '0, 0, 0, 0);
    drive_cycle(0, 0, 1, 6'd3, 0, '0, 0, 0, 1);
    n_tests++;
    if (o_restore !== 1 || o_av0 !== 0 || o_av1 !== 0 || o_cnt !== 4 || o_we0 !== 1 || o_wd0 !== 3) begin
      n_fail++; $display("FAIL restore got rst=%b av=%b%b cnt=%0d we=%b d=%0d want 1 00 4 1 3",
        o_restore, o_av0, o_av1, o_cnt, o_we0, o_wd0);
    end
    drive_cycle(1, 1, 0, '0, 0, '0, 0, 0, 0);
    n_tests++;
    if (o_cnt !== 7 || o_busy !== 0) begin
      n_fail++; $display("FAIL restore_count got cnt=%0d busy=%b want 7 0", o_cnt, o_busy);
    end
    idle(1);
    n_tests++;
    if (o_at0 !== 11 || o_at1 !== 12 || o_cnt !== 5) begin
      n_fail++; $display("FAIL restore_tags got %0d %0d cnt=%0d want 11 12 5", o_at0, o_at1, o_cnt);
    end
  endtask

  task automatic test_one_remaining();
    for (int i = 0; i < 10 && rq.size() > 1; i++) drive_cycle(1, 1, 0, '0, 0, '0, 0, 0, 0);
    drive_cycle(1, 1, 0, '0, 0, '0, 0, 0, 0);
    n_tests++;
    if (o_cnt !== 1 || o_gnt0 !== 1 || o_gnt1 !== 0 || o_re1 !== 0) begin
      n_fail++; $display("FAIL one_remaining got cnt=%0d gnt=%b%b re1=%b want 1 10 0", o_cnt, o_gnt0, o_gnt1, o_re1);
    end
    drive_cycle(1, 1, 0, '0, 0, '0, 0, 0, 0);
    n_tests++;
    if (o_cnt !== 0 || o_gnt0 !== 0 || o_av0 !== 1 || o_at0 !== 3 || o_av1 !== 0) begin
      n_fail++; $display("FAIL empty got cnt=%0d gnt0=%b av=%b%b tag=%0d want 0 0 10 3", o_cnt, o_gnt0, o_av0, o_av1, o_at0);
    end
  endtask

  task automatic test_errors();
    reseed();
    drive_cycle(0, 0, 1, 6'd5, 0, '0, 0, 0, 0);
    n_tests++;
    if (o_we0 !== 0 || o_err !== 0) begin
      n_fail++; $display("FAIL free_full got we=%b err=%b want 0 0", o_we0, o_err);
    end
    idle(1);
    n_tests++;
    if (o_err !== 1 || o_cnt !== 8) begin
      n_fail++; $display("FAIL free_full_err got err=%b cnt=%0d want 1 8", o_err, o_cnt);
    end
    reseed();
    drive_cycle(1, 0, 0, '0, 0, '0, 0, 0, 0);
    drive_cycle(0, 0, 1, 6'd4, 1, 6'd5, 0, 0, 0);
    n_tests++;
    if (o_cnt !== 7 || o_we0 !== 1 || o_we1 !== 0 || o_err !== 0) begin
      n_fail++; $display("FAIL one_slot got cnt=%0d we=%b%b err=%b want 7 10 0", o_cnt, o_we0, o_we1, o_err);
    end
    idle(1);
    n_tests++;
    if (o_err !== 1 || o_cnt !== 8) begin
      n_fail++; $display("FAIL one_slot_err got err=%b cnt=%0d want 1 8", o_err, o_cnt);
    end
    reseed();
    drive_cycle(0, 0, 0, '0, 0, '0, 1, 0, 0);
    drive_cycle(0, 0, 0, '0, 0, '0, 1, 0, 0);
    n_tests++;
    if (o_ckpt !== 0 || o_busy !== 1 || o_err !== 0) begin
      n_fail++; $display("FAIL ckpt_refuse got ckpt=%b busy=%b err=%b want 0 1 0", o_ckpt, o_busy, o_err);
    end
    drive_cycle(0, 0, 0, '0, 0, '0, 1, 1, 0);
    n_tests++;
    if (o_ckpt !== 1 || o_err !== 1) begin
      n_fail++; $display("FAIL ckpt_resolve_retake got ckpt=%b err=%b want 1 1", o_ckpt, o_err);
    end
    idle(1);
    n_tests++;
    if (o_busy !== 1) begin
      n_fail++; $display("FAIL ckpt_retake_busy got %b want 1", o_busy);
    end
    reseed();
    drive_cycle(0, 0, 0, '0, 0, '0, 0, 0, 1);
    n_tests++;
    if (o_restore !== 0) begin
      n_fail++; $display("FAIL misp_no_ckpt_strobe got %b want 0", o_restore);
    end
    idle(1);
    n_tests++;
    if (o_err !== 1 || o_busy !== 0) begin
      n_fail++; $display("FAIL misp_no_ckpt_err got err=%b busy=%b want 1 0", o_err, o_busy);
    end
  endtask

  task automatic test_random();
    bit r0, r1, f0v, f1v, ck, res, mis;
    int room;
    reseed();
    for (int i = 0; i < 400; i++) begin
      r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1));
      f0v = ($urandom_range(0, 2) == 0); f1v = ($urandom_range(0, 2) == 0);
      ck = ($urandom_range(0, 7) == 0); res = ($urandom_range(0, 7) == 0); mis = ($urandom_range(0, 9) == 0);
      if (r_busy) begin
        room = FL_DEPTH - snap_q.size() - since_q.size();
        if (room < 2) f1v = 0;
        if (room < 1) f0v = 0;
      end
      drive_cycle(r0, r1, f0v, PREG_W'($urandom_range(0, NUM_PREGS - 1)),
                  f1v, PREG_W'($urandom_range(0, NUM_PREGS - 1)), ck, res, mis);
      n_tests++;
      if ({o_gnt0, o_gnt1, o_re0, o_re1, o_we0, o_we1, o_ckpt, o_restore, o_av0, o_av1, o_ready, o_busy, o_err} !==
          {e_gnt0, e_gnt1, e_re0, e_re1, e_we0, e_we1, e_ckpt, e_restore, e_av0, e_av1, e_ready, e_busy, e_err}) begin
        n_fail++; $display("FAIL rand_ctl cyc%0d got %b want %b", i,
          {o_gnt0, o_gnt1, o_re0, o_re1, o_we0, o_we1, o_ckpt, o_restore, o_av0, o_av1, o_ready, o_busy, o_err},
          {e_gnt0, e_gnt1, e_re0, e_re1, e_we0, e_we1, e_ckpt, e_restore, e_av0, e_av1, e_ready, e_busy, e_err});
      end
      n_tests++;
      if ({o_at0, o_at1, (o_we0 ? o_wd0 : {PREG_W{1'b0}}), (o_we1 ? o_wd1 : {PREG_W{1'b0}})} !==
          {e_at0, e_at1, (e_we0 ? e_wd0 : {PREG_W{1'b0}}), (e_we1 ? e_wd1 : {PREG_W{1'b0}})}) begin
        n_fail++; $display("FAIL rand_data cyc%0d got tags %0d,%0d wd %0d,%0d want %0d,%0d %0d,%0d", i,
          o_at0, o_at1, o_wd0, o_wd1, e_at0, e_at1, e_wd0, e_wd1);
      end
      n_tests++;
      if (o_cnt !== CNT_W'(e_cnt)) begin
        n_fail++; $display("FAIL rand_count cyc%0d got %0d want %0d", i, o_cnt, e_cnt);
      end
    end
  endtask

  task automatic test_reset_midrun();
    drive_cycle(1, 1, 0, '0, 0, '0, 0, 0, 0);
    @(negedge clk); #2;
    assert_reset();
    #1;
    n_tests++;
    if (ready !== 0 || free_count !== '0 || alloc_vld0 !== 0 || fl_i0_write_enable !== 0) begin
      n_fail++; $display("FAIL midrun_reset got ready=%b cnt=%0d av0=%b we0=%b want 0 0 0 0",
        ready, free_count, alloc_vld0, fl_i0_write_enable);
    end
    release_reset();
    test_seeding();
  endtask

  initial begin
    fl_bad = 0;
    test_reset();
    test_seeding();
    test_dual_alloc();
    test_ckpt_restore();
    test_one_remaining();
    test_errors();
    test_random();
    test_reset_midrun();
    n_tests++;
    if (fl_bad !== 0) begin
      n_fail++; $display("FAIL freelist_misuse got %0d events want 0", fl_bad);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
